// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: op field layout, size codes, FSM states
// and exception bit positions.
package mem_pkg;

  typedef struct packed {
    logic       ld;
    logic       st;
    logic       uns;
    logic [1:0] size;
  } mem_op_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } mem_state_t;

  localparam int EXCP_ADEL = 0;
  localparam int EXCP_ADES = 1;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus: store enables/replication and load
// extract with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int LB     = $clog2(NB)
) (
  input  logic [LB-1:0]     lane,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] st_lanes,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] low_mask;
  logic              sgn;

  always_comb begin
    int nbytes;
    int nbits;
    nbytes   = 1 << size;
    // D on a 32-bit bus is caught by the top-level assertion; clamp to stay in range.
    if (nbytes > NB) nbytes = NB;
    nbits    = 8 * nbytes;
    be       = NB'(((1 << nbytes) - 1) << lane);
    st_lanes = '0;
    for (int i = 0; i < NB; i++)
      st_lanes[8*i +: 8] = st_data[8*(i % nbytes) +: 8];
    shifted  = rd_data >> {lane, 3'b000};
    low_mask = {DATA_W{1'b1}} >> (DATA_W - nbits);
    sgn      = ~uns & shifted[nbits-1];
    ld_data  = (shifted & low_mask) | ({DATA_W{sgn}} & ~low_mask);
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: holds one EX result, runs loads/stores over a req/gnt +
// rvalid bus, flags misalignment, forwards to ID and hands results to WB.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  parameter  int RF_AW  = 5,
  localparam int NB     = DATA_W / 8,
  localparam int LB     = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [4:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_rf_we,
  input  logic [RF_AW-1:0]  in_rf_waddr,
  input  logic [DATA_W-1:0] in_ex_result,
  output logic              dbus_req,
  output logic              dbus_wr,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [NB-1:0]     dbus_be,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_rf_we,
  output logic [RF_AW-1:0]  out_rf_waddr,
  output logic [DATA_W-1:0] out_rf_wdata,
  output logic [1:0]        out_excp,
  output logic [ADDR_W-1:0] out_badvaddr,
  output logic              fwd_we,
  output logic [RF_AW-1:0]  fwd_waddr,
  output logic [DATA_W-1:0] fwd_wdata,
  output logic              fwd_pending
);

  mem_state_t        state_q, state_d;
  mem_op_t           in_o, pl_op;
  logic [ADDR_W-1:0] pl_pc, pl_addr, pl_badvaddr;
  logic [DATA_W-1:0] pl_wdata, pl_result;
  logic              pl_rf_we;
  logic [RF_AW-1:0]  pl_waddr;
  logic [1:0]        pl_excp;

  logic              in_mem, in_mis, acc, is_req, is_done;
  logic [1:0]        in_excp;
  mem_state_t        acc_state;
  logic [NB-1:0]     al_be;
  logic [DATA_W-1:0] al_wdata, al_ldata;

  assign in_o      = mem_op_t'(in_op);
  assign in_mem    = in_o.ld | in_o.st;
  assign in_mis    = in_mem & (|(in_addr[2:0] & align_mask(in_o.size)));
  assign in_excp   = in_mis ? (in_o.ld ? 2'b01 : 2'b10) : 2'b00;
  assign acc_state = (in_mem & ~in_mis) ? ST_REQ : ST_DONE;

  assign is_req   = (state_q == ST_REQ);
  assign is_done  = (state_q == ST_DONE);
  assign in_ready = rst & ((state_q == ST_IDLE) | (is_done & out_ready));
  assign acc      = in_valid & in_ready & ~flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (acc) state_d = acc_state;
      ST_REQ: begin
        if (flush)         state_d = (dbus_gnt & pl_op.ld) ? ST_DRAIN : ST_IDLE;
        else if (dbus_gnt) state_d = pl_op.ld ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: begin
        if (flush)            state_d = dbus_rvalid ? ST_IDLE : ST_DRAIN;
        else if (dbus_rvalid) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (flush)          state_d = ST_IDLE;
        else if (out_ready) state_d = acc ? acc_state : ST_IDLE;
      end
      ST_DRAIN: if (dbus_rvalid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pl_pc       <= '0;
      pl_op       <= '0;
      pl_addr     <= '0;
      pl_wdata    <= '0;
      pl_rf_we    <= 1'b0;
      pl_waddr    <= '0;
      pl_result   <= '0;
      pl_excp     <= '0;
      pl_badvaddr <= '0;
    end else if (acc) begin
      pl_pc       <= in_pc;
      pl_op       <= in_o;
      pl_addr     <= in_addr;
      pl_wdata    <= in_wdata;
      pl_rf_we    <= in_rf_we;
      pl_waddr    <= in_rf_waddr;
      pl_result   <= in_ex_result;
      pl_excp     <= in_excp;
      pl_badvaddr <= in_mis ? in_addr : '0;
    end else if ((state_q == ST_WAIT) && dbus_rvalid && !flush) begin
      pl_result   <= al_ldata;
    end
  end

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .lane     (pl_addr[LB-1:0]),
    .size     (pl_op.size),
    .uns      (pl_op.uns),
    .st_data  (pl_wdata),
    .rd_data  (dbus_rdata),
    .be       (al_be),
    .st_lanes (al_wdata),
    .ld_data  (al_ldata)
  );

  // Bus fields are driven only while requesting so they read zero otherwise.
  assign dbus_req   = is_req;
  assign dbus_wr    = is_req & pl_op.st;
  assign dbus_addr  = is_req ? {pl_addr[ADDR_W-1:LB], {LB{1'b0}}} : '0;
  assign dbus_be    = is_req ? al_be : '0;
  assign dbus_wdata = (is_req & pl_op.st) ? al_wdata : '0;

  assign out_valid    = is_done;
  assign out_pc       = pl_pc;
  assign out_rf_we    = pl_rf_we & ~|pl_excp;
  assign out_rf_waddr = pl_waddr;
  assign out_rf_wdata = pl_result;
  assign out_excp     = pl_excp;
  assign out_badvaddr = pl_badvaddr;

  assign fwd_we      = is_done & pl_rf_we & ~|pl_excp;
  assign fwd_waddr   = pl_waddr;
  assign fwd_wdata   = pl_result;
  assign fwd_pending = (is_req | (state_q == ST_WAIT)) & pl_op.ld & pl_rf_we;

  a_no_dword_on_32: assert property (@(posedge clk) disable iff (!rst)
    (in_valid && in_ready && (in_o.ld || in_o.st) && in_o.size == SZ_D) |-> (DATA_W == 64));

endmodule
